// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, forwarding encodings and multiply FSM states for the 8-bit core
package cpu_pkg;
    localparam int DATA_W = 8;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SLT   = 4'd7;
    localparam logic [3:0] OP_PASSB = 4'd8;
    localparam logic [3:0] OP_MUL   = 4'd9;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_WB    = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;
endpackage

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add multiplier keeping the low DATA_W product bits, one step per cycle
module seq_multiplier #(
    parameter int DATA_W     = 8,
    parameter int MUL_CYCLES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] product
);
    localparam int CNT_W = $clog2(MUL_CYCLES);

    logic [DATA_W-1:0] mcand, mplier;
    logic [CNT_W-1:0]  cnt;

    assign done = busy && cnt == CNT_W'(MUL_CYCLES - 1);

    // latch operands on start, then add the shifted multiplicand for each set multiplier bit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
        end else if (abort) begin
            product <= '0;
            cnt     <= '0;
            busy    <= 1'b0;
        end else if (start) begin
            mcand   <= a;
            mplier  <= b;
            product <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
        end else if (busy) begin
            product <= product + (mplier[0] ? mcand : '0);
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            cnt     <= cnt + 1'b1;
            busy    <= !done;
        end
    end
endmodule

// File: rtl/execute_stage.sv
// execute_stage: forwarding, ALU and EX/MEM register; EXEC_MUL_EN adds the multi-cycle MUL
module execute_stage #(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3,
    parameter int MUL_CYCLES = DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [3:0]            alu_op,
    input  logic [DATA_W-1:0]     rs1_data,
    input  logic [DATA_W-1:0]     rs2_data,
    input  logic [DATA_W-1:0]     imm,
    input  logic                  use_imm,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic                  reg_write_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic [1:0]            forward_A,
    input  logic [1:0]            forward_B,
    input  logic [DATA_W-1:0]     ex_mem_fwd,
    input  logic [DATA_W-1:0]     wb_data,
    input  logic                  flush,
    output logic [DATA_W-1:0]     alu_result,
    output logic [DATA_W-1:0]     write_data,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  reg_write,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic [1:0]            forward_B_out,
    output logic                  zero,
    output logic                  valid_out,
    output logic                  stall_out
);
    import cpu_pkg::*;

    logic [DATA_W-1:0] op_a, op_b_rf, op_b, result;
    logic              valid_eff;

    assign valid_eff = valid_in && !flush && !stall_out;

    // operand forwarding; store data always takes the forwarded rs2, never the immediate
    always_comb begin
        op_a    = forward_A == FWD_WB ? wb_data : forward_A == FWD_EXMEM ? ex_mem_fwd : rs1_data;
        op_b_rf = forward_B == FWD_WB ? wb_data : forward_B == FWD_EXMEM ? ex_mem_fwd : rs2_data;
        op_b    = use_imm ? imm : op_b_rf;
    end

`ifdef EXEC_MUL_EN
    mul_state_t        state, state_nx;
    logic              mul_req, mul_start, mul_abort, mul_busy, mul_done, stall;
    logic [DATA_W-1:0] product;

    assign mul_req   = valid_in && alu_op == OP_MUL && !flush;
    assign stall_out = reset && stall;

    seq_multiplier #(.DATA_W(DATA_W), .MUL_CYCLES(MUL_CYCLES)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .abort   (mul_abort),
        .a       (op_a),
        .b       (op_b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );

    // multiply FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // DONE releases the stall so the product is captured as upstream advances past the MUL
    always_comb begin
        state_nx  = state;
        stall     = 1'b0;
        mul_start = 1'b0;
        mul_abort = 1'b0;
        case (state)
            IDLE: if (mul_req) begin
                stall     = 1'b1;
                mul_start = 1'b1;
                state_nx  = BUSY;
            end
            BUSY: begin
                stall     = mul_busy;
                mul_abort = flush;
                state_nx  = flush ? IDLE : mul_done ? DONE : BUSY;
            end
            default: state_nx = IDLE;
        endcase
    end
`else
    assign stall_out = 1'b0;
`endif

    // ALU; unused opcodes give zero while control still passes through
    always_comb begin
        result = '0;
        case (alu_op)
            OP_ADD:   result = op_a + op_b;
            OP_SUB:   result = op_a - op_b;
            OP_AND:   result = op_a & op_b;
            OP_OR:    result = op_a | op_b;
            OP_XOR:   result = op_a ^ op_b;
            OP_SLL:   result = op_a << op_b[2:0];
            OP_SRL:   result = op_a >> op_b[2:0];
            OP_SLT:   result = {{(DATA_W-1){1'b0}}, $signed(op_a) < $signed(op_b)};
            OP_PASSB: result = op_b;
`ifdef EXEC_MUL_EN
            OP_MUL:   result = product;
`endif
            default:  result = '0;
        endcase
    end

    // EX/MEM boundary, updated every cycle; bubbles are written as all-zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            alu_result    <= '0;
            write_data    <= '0;
            rd_out        <= '0;
            reg_write     <= 1'b0;
            MemRead       <= 1'b0;
            MemWrite      <= 1'b0;
            forward_B_out <= '0;
            zero          <= 1'b0;
            valid_out     <= 1'b0;
        end else begin
            alu_result    <= valid_eff ? result : '0;
            write_data    <= valid_eff ? op_b_rf : '0;
            rd_out        <= valid_eff ? rd_in : '0;
            reg_write     <= valid_eff && reg_write_in;
            MemRead       <= valid_eff && mem_read_in;
            MemWrite      <= valid_eff && mem_write_in;
            forward_B_out <= valid_eff ? forward_B : '0;
            zero          <= valid_eff && result == '0;
            valid_out     <= valid_eff;
        end
    end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- ID/EX-to-EX/MEM stage of the 8-bit pipelined core.
- Resolves operand forwarding, runs the ALU (including an optional multi-cycle multiplier) and registers the results into the EX/MEM boundary.
- Its registered outputs drive memory_stage directly: alu_result is the memory address, write_data is the store data, and forward_B, MemRead and MemWrite pass through.
- Asserts stall_out to freeze upstream stages while a multiply is in flight.

Parameters:
- DATA_W, 8, datapath width (MUL_CYCLES tracks it).
- REG_ADDR_W, 3, destination register index width.
- MUL_CYCLES, 8, shift-add iterations per multiply (equals DATA_W).

Ports:
- clk  in  1  clock; one clock domain.
- reset  in  1  reset; asynchronous and active-low.
- valid_in  in  1  ID/EX holds a real instruction.
- alu_op  in  4  operation code.
- rs1_data  in  DATA_W  register-file operand A.
- rs2_data  in  DATA_W  register-file operand B.
- imm  in  DATA_W  immediate.
- use_imm  in  1  1 selects imm as ALU B; store data always uses forwarded rs2.
- rd_in  in  REG_ADDR_W  destination register.
- reg_write_in, mem_read_in, mem_write_in  in  1 each  control bits.
- forward_A, forward_B  in  2 each  00 = register file, 01 = wb_data, 10 = ex_mem_fwd, 11 = register file.
- ex_mem_fwd  in  DATA_W  forwarded EX/MEM result.
- wb_data  in  DATA_W  forwarded write-back value.
- flush  in  1  squash the current instruction.
- alu_result  out  DATA_W  registered result; memory address.
- write_data  out  DATA_W  registered forwarded rs2.
- rd_out  out  REG_ADDR_W  registered destination register.
- reg_write, MemRead, MemWrite  out  1 each  registered control.
- forward_B_out  out  2  registered forward_B, for memory_stage.
- zero  out  1  registered (result == 0).
- valid_out  out  1  EX/MEM holds a real instruction.
- stall_out  out  1  combinational hold request to IF/ID.

Behaviour:
- Reset (reset low, async): every registered output is 0; FSM goes to IDLE; counter and accumulator clear. stall_out = 0 while in reset.
- Opcodes:
  - 0 ADD, 1 SUB: mod 2^8, wrap silently, no carry out.
  - 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL: shift amount is B[2:0].
  - 7 SLT: signed two's-complement compare, result 0x01 or 0x00.
  - 8 PASSB.
  - 9 MUL: low 8 bits of the product.
  - 10–15: result 0x00, control passes through unchanged.
- Single-cycle ops: result and control are captured at the next rising edge (latency 1). EX/MEM updates every cycle; there is no enable.
- Bubble: valid_out = 0 with reg_write, MemRead and MemWrite = 0; alu_result, write_data, rd_out, forward_B_out and zero are don't-care (implemented as 0). A bubble is inserted when any of these holds:
  - valid_in = 0;
  - flush = 1 (flush has priority over everything);
  - stall_out = 1.
- MUL FSM:
  - IDLE, with valid_in & alu_op == MUL & !flush: stall_out = 1; latch operands; go to BUSY, counter = 0.
  - BUSY: one shift-add step per cycle; stall_out = 1; after MUL_CYCLES steps go to DONE.
  - DONE: stall_out = 0. At the edge, EX/MEM captures the product and control, and the FSM returns to IDLE. Upstream advances on the same edge, so the still-present MUL is not restarted.
  - Total stall: MUL_CYCLES + 1 cycles per multiply.
- flush in BUSY or DONE: abort, return to IDLE, insert a bubble, stall_out drops in the next cycle, and no result is produced.
- Operands are latched at MUL start; forwarding inputs that change during BUSY have no effect.
- reset low mid-multiply: immediate IDLE with all outputs cleared.

Optional Feature:
- Macro EXEC_MUL_EN.
- Defined: MUL opcode, FSM and multiplier are present as described above.
- Undefined: opcode 9 behaves as an undefined opcode (result 0x00, single cycle); stall_out is tied 0; no FSM or multiplier logic is synthesised.

Decomposition:
- cpu_pkg holds:
  - the ALU opcode localparams;
  - the forwarding encodings FWD_REG / FWD_WB / FWD_EXMEM;
  - the FSM state encodings IDLE / BUSY / DONE;
  - DATA_W.
- memory_stage is to import the same forwarding encodings.
- One sub-module, seq_multiplier (start, operands, busy, done, product), owns the counter and accumulator. It is instantiated only under EXEC_MUL_EN.

Test Plan:
- Reset: hold reset low with valid ADD inputs applied → all outputs 0 and stall_out 0; after release, first ADD appears after 1 edge.
- Forwarding: rs1 = 0x05, forward_A = 10, ex_mem_fwd = 0x30, use_imm = 1, imm = 0x12, ADD → alu_result 0x42, zero 0.
- Arithmetic edges:
  - SUB 0x03 − 0x05 → 0xFE;
  - SUB 0x07 − 0x07 → 0x00 with zero = 1;
  - SLT 0x80 vs 0x01 → 0x01;
  - SLL 0x81 by B = 0x09 → 0x02.
- Multiply (EXEC_MUL_EN): MUL 0x0D × 0x0B → stall_out high for 9 cycles with bubbles, then alu_result = 0x8F with valid_out = 1 and no re-issue; without EXEC_MUL_EN, opcode 9 → 0x00 after 1 cycle with stall_out = 0.
- Flush in multiply: flush in BUSY cycle 3 → bubble, stall_out low next cycle, no MUL result; a following ADD 0x01 + 0x01 → 0x02.
- Store path: mem_write_in = 1, forward_B = 01, wb_data = 0xA5, use_imm = 1, imm = 0x10 → alu_result 0x10 (rs1 = 0), write_data 0xA5, MemWrite 1, forward_B_out 01.
